// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: retires one multiplier bit per clock using an
// n+1-bit accumulator so the most-negative operand multiplies exactly.
module booth_seq_mult #(
  parameter int n = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [n-1:0]   multiplicand,
  input  logic signed [n-1:0]   multiplier,
  output logic signed [2*n-1:0] product,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic signed [n:0]   a, m;
  logic [n-1:0]        q;
  logic                q1;
  logic [CW-1:0]       count;
  logic signed [n:0]   a_sum, a_sh;
  logic [n-1:0]        q_sh;
  logic                q1_sh;
  logic                accept, last;

  function automatic logic signed [n:0] booth_add(input logic [1:0] sel,
                                                  input logic signed [n:0] acc,
                                                  input logic signed [n:0] mc);
    case (sel)
      2'b01:   booth_add = acc + mc;
      2'b10:   booth_add = acc - mc;
      default: booth_add = acc;
    endcase
  endfunction

  // Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q_1}
  always_comb begin
    a_sum = booth_add({q[0], q1}, a, m);
    a_sh  = {a_sum[n], a_sum[n:1]};
    q_sh  = {a_sum[0], q[n-1:1]};
    q1_sh = q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nx = RUN;
      end
      RUN: begin
        last = (count == LAST);
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q1      <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      a     <= '0;
      m     <= {multiplicand[n-1], multiplicand};
      q     <= multiplier;
      q1    <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      a     <= a_sh;
      q     <= q_sh;
      q1    <= q1_sh;
      count <= count + 1'b1;
      // product is written only once, from the post-shift values of the final step
      if (last) product <= {a_sh[n-1:0], q_sh};
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (n=8): vector table plus handshake and reset sequences.
module tb_booth_seq_mult;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [7:0]  multiplicand;
  logic signed [7:0]  multiplier;
  logic signed [15:0] product;
  logic               busy;
  logic               done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  booth_seq_mult #(.n(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy && done) begin
      n_err++;
      $display("FAIL busy_done_overlap: got busy=%b done=%b expected not both", busy, done);
    end
  end

  function automatic logic [7:0] lfsr_nx(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      bc  += int'(busy);
      lat++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_mult(input logic [7:0] mc, input logic [7:0] mp,
                          input logic [15:0] exp, input string nm);
    int lat, bc;
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk({nm, "_latency"}, lat, 32'd8);
    chk({nm, "_busy_cycles"}, bc, 32'd8);
    chk({nm, "_product"}, {16'd0, product}, {16'd0, exp});
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({nm, "_done_single"}, {31'd0, done}, 32'd0);
    chk({nm, "_product_held"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    int lat, bc, last_acc, w;
    logic [7:0]  lfsr, cur_mc, cur_mp;
    logic signed [7:0]  sa, sb;
    logic signed [15:0] e, prev;
    bit any_done;

    vecs[0]  = '{8'd3,    8'd5,    16'h000F, "3x5"};
    vecs[1]  = '{8'hF9,   8'd6,    16'hFFD6, "m7x6"};
    vecs[2]  = '{8'd127,  8'h80,   16'hC080, "127xm128"};
    vecs[3]  = '{8'h80,   8'h80,   16'h4000, "m128xm128"};
    vecs[4]  = '{8'd0,    8'hFF,   16'h0000, "0xm1"};
    vecs[5]  = '{8'hFF,   8'hFF,   16'h0001, "m1xm1"};
    vecs[6]  = '{8'h80,   8'd127,  16'hC080, "m128x127"};
    vecs[7]  = '{8'd1,    8'h80,   16'hFF80, "1xm128"};
    vecs[8]  = '{8'h80,   8'd1,    16'hFF80, "m128x1"};
    vecs[9]  = '{8'd127,  8'd127,  16'h3F01, "127x127"};
    vecs[10] = '{8'd2,    8'd3,    16'h0006, "2x3"};

    rst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #1;
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_mult(vecs[i].mc, vecs[i].mp, vecs[i].exp, vecs[i].nm);

    // start raised only while in DONE must be ignored
    multiplicand = 8'd4; multiplier = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk("4x4_product", {16'd0, product}, 32'h10);
    multiplicand = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
    chk("start_in_done_product", {16'd0, product}, 32'h10);

    // start held high continuously, LFSR operands, junk operands mid-RUN
    prev = 16'sh0010;
    lfsr = 8'hA5;
    cur_mc = lfsr; lfsr = lfsr_nx(lfsr);
    cur_mp = lfsr; lfsr = lfsr_nx(lfsr);
    multiplicand = cur_mc; multiplier = cur_mp; start = 1'b1;
    last_acc = 0;
    for (int it = 0; it < 4; it++) begin
      w = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (busy) break;
        w++;
      end
      chk("hs_accept_seen", {31'd0, busy}, 32'd1);
      if (it > 0) chk("hs_spacing", cyc - last_acc, 32'd10);
      last_acc = cyc;
      sa = cur_mc; sb = cur_mp;
      e = sa * sb;
      repeat (2) @(negedge clk);
      chk("hs_midrun_product_held", {16'd0, product}, {16'd0, prev});
      multiplicand = 8'h55; multiplier = 8'h33;
      wait_done(lat, bc);
      chk("hs_product", {16'd0, product}, {16'd0, e});
      prev = e;
      if (it < 3) begin
        cur_mc = lfsr; lfsr = lfsr_nx(lfsr);
        cur_mp = lfsr; lfsr = lfsr_nx(lfsr);
        multiplicand = cur_mc; multiplier = cur_mp;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);

    // asynchronous reset four cycles into RUN
    multiplicand = 8'd5; multiplier = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
    chk("midrun_reset_done", {31'd0, done}, 32'd0);
    chk("midrun_reset_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, any_done}, 32'd0);
    chk("product_zero_after_reset", {16'd0, product}, 32'd0);
    run_mult(8'd2, 8'd3, 16'h0006, "post_reset_2x3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
